// File: rtl/rob_pkg.sv
// Shared sizing and entry types for the reorder-buffer drain path.
package rob_pkg;

  localparam int ROB_ADDR_WIDTH = 4;
  localparam int ROB_DATA_WIDTH = 32;

  typedef logic [ROB_ADDR_WIDTH-1:0] rob_idx_t;

  typedef struct packed {
    rob_idx_t                  idx;
    logic [ROB_DATA_WIDTH-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_skid_fifo.sv
// Two-entry skid FIFO holding drained ROB entries; occupancy count feeds the reader's credit check.
module rob_skid_fifo
  import rob_pkg::*;
#(
  parameter type entry_t = rob_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       push_i,
  input  entry_t     push_data_i,
  input  logic       pop_i,
  output entry_t     head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Clear only empties the FIFO; stale payload stays in storage but is never presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clear_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rob_reader.sv
// In-order ROB drain engine: walks the head, reads each valid entry from the data RAM,
// clears its valid bit and streams it out through a 2-entry skid buffer.
module rob_reader
  import rob_pkg::*;
#(
  parameter int ADDR_WIDTH = ROB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH-1:0] valid_addr_o,
  input  logic                  valid_i,
  output logic                  valid_clr_o,
  output logic [ADDR_WIDTH-1:0] valid_clr_addr_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ADDR_WIDTH-1:0] out_idx_o,
  output logic [ADDR_WIDTH:0]   retired_cnt_o
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam logic [ADDR_WIDTH:0] CNT_MAX = '1;

  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_idx_q, inflight_idx_d;
  logic [ADDR_WIDTH:0]   retired_q, retired_d;

  logic       pop, issue, credit_ok;
  logic [2:0] occupancy;
  logic       fifo_push, fifo_full, fifo_empty;
  logic [1:0] fifo_count;
  entry_t     fifo_wdata, fifo_head;

  assign pop = out_valid_o && out_ready_i;

  // Buffered entries plus the read in flight must leave a slot once this cycle's pop is counted.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign credit_ok = (occupancy - {2'b00, pop}) <= 3'd1;
  assign issue     = rst_n && !flush_i && valid_i && credit_ok;

  assign fifo_push  = inflight_q && !flush_i && (!fifo_full || pop);
  assign fifo_wdata = '{idx: inflight_idx_q, data: rd_data_i};

  rob_skid_fifo #(
    .entry_t(entry_t)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (flush_i),
    .push_i     (fifo_push),
    .push_data_i(fifo_wdata),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_comb begin
    head_d         = head_q;
    inflight_d     = issue;
    inflight_idx_d = inflight_idx_q;
    retired_d      = retired_q;
    if (issue) begin
      head_d         = head_q + ADDR_WIDTH'(1);
      inflight_idx_d = head_q;
    end
    if (pop && (retired_q != CNT_MAX)) begin
      retired_d = retired_q + (ADDR_WIDTH + 1)'(1);
    end
    if (flush_i) begin
      head_d     = '0;
      inflight_d = 1'b0;
      retired_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      retired_q      <= '0;
    end else begin
      head_q         <= head_d;
      inflight_q     <= inflight_d;
      inflight_idx_q <= inflight_idx_d;
      retired_q      <= retired_d;
    end
  end

  assign valid_addr_o     = head_q;
  assign rd_en_o          = issue;
  assign rd_addr_o        = head_q;
  assign valid_clr_o      = issue;
  assign valid_clr_addr_o = head_q;
  assign out_valid_o      = !fifo_empty;
  assign out_data_o       = fifo_head.data;
  assign out_idx_o        = fifo_head.idx;
  assign retired_cnt_o    = retired_q;

endmodule

// File: tb/tb_rob_reader.sv
// Bench for rob_reader: a valid-bitmap/RAM environment, a queue-based ROB model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_rob_reader;

  localparam int AW      = 4;
  localparam int DW      = 32;
  localparam int DEPTH   = 1 << AW;
  localparam int CNT_MAX = (1 << (AW + 1)) - 1;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic          flush_i     = 1'b0;
  logic          out_ready_i = 1'b0;
  logic [AW-1:0] valid_addr_o, valid_clr_addr_o, rd_addr_o, out_idx_o;
  logic          valid_i, valid_clr_o, rd_en_o, out_valid_o;
  logic [DW-1:0] rd_data_i, out_data_o;
  logic [AW:0]   retired_cnt_o;

  int err_count   = 0;
  int check_count = 0;

  rob_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .valid_addr_o    (valid_addr_o),
    .valid_i         (valid_i),
    .valid_clr_o     (valid_clr_o),
    .valid_clr_addr_o(valid_clr_addr_o),
    .rd_en_o         (rd_en_o),
    .rd_addr_o       (rd_addr_o),
    .rd_data_i       (rd_data_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_data_o      (out_data_o),
    .out_idx_o       (out_idx_o),
    .retired_cnt_o   (retired_cnt_o)
  );

  always #5 clk = ~clk;

  // Producer-side environment: valid bitmap, data RAM with one-cycle read latency.
  logic [DEPTH-1:0] vmem     = '0;
  logic [DEPTH-1:0] set_mask = '0;
  logic [DW-1:0]    ram_mem  [DEPTH];
  logic [DW-1:0]    set_data [DEPTH];
  logic [DW-1:0]    rd_data_q = '0;

  assign valid_i   = vmem[valid_addr_o];
  assign rd_data_i = rd_data_q;

  always @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (set_mask[i]) begin
        vmem[i]    <= 1'b1;
        ram_mem[i] <= set_data[i];
      end else if (valid_clr_o && (valid_clr_addr_o == AW'(i))) begin
        vmem[i] <= 1'b0;
      end
    end
    rd_data_q <= rd_en_o ? ram_mem[rd_addr_o] : $urandom;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic flush_v, input logic ready_v);
    @(posedge clk);
    #1;
    rst_n       = rst_v;
    flush_i     = flush_v;
    out_ready_i = ready_v;
    set_mask    = '0;
  endtask

  task automatic setValid(input int idx, input logic [DW-1:0] d);
    if (!vmem[idx] && !set_mask[idx]) begin
      set_mask[idx] = 1'b1;
      set_data[idx] = d;
    end
  endtask

  // Reference model: entries issued in index order, each visible two cycles after its issue.
  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    int            t;
  } item_t;

  item_t         issued[$];
  item_t         new_item;
  int            cyc       = 0;
  logic [AW-1:0] m_head    = '0;
  int            m_retired = 0;
  bit            exp_valid, exp_pop, exp_issue;

  always @(negedge clk) begin
    cyc++;
    exp_valid = 1'b0;
    if (issued.size() > 0) exp_valid = (issued[0].t <= cyc - 2);
    checkOutput("out_valid", out_valid_o, exp_valid);
    if (exp_valid) begin
      checkOutput("out_idx", out_idx_o, issued[0].idx);
      checkOutput("out_data", out_data_o, issued[0].data);
    end
    exp_pop   = exp_valid && out_ready_i;
    exp_issue = rst_n && !flush_i && vmem[m_head] &&
                ((issued.size() - (exp_pop ? 1 : 0)) <= 1);
    checkOutput("valid_addr", valid_addr_o, m_head);
    checkOutput("rd_en", rd_en_o, exp_issue);
    checkOutput("valid_clr", valid_clr_o, exp_issue);
    if (exp_issue) begin
      checkOutput("rd_addr", rd_addr_o, m_head);
      checkOutput("valid_clr_addr", valid_clr_addr_o, m_head);
    end
    checkOutput("retired_cnt", retired_cnt_o, m_retired);

    if (!rst_n || flush_i) begin
      issued.delete();
      m_head    = '0;
      m_retired = 0;
    end else begin
      if (exp_pop) begin
        void'(issued.pop_front());
        if (m_retired < CNT_MAX) m_retired++;
      end
      if (exp_issue) begin
        new_item.idx  = m_head;
        new_item.data = ram_mem[m_head];
        new_item.t    = cyc;
        issued.push_back(new_item);
        m_head = m_head + 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_issue;
    int acc_idx[$];
    int acc_cyc[$];
    logic ready_v;

    // Reset, then a single entry at index 0.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk); #1;
    checkOutput("reset_out_valid", out_valid_o, 0);
    checkOutput("reset_rd_en", rd_en_o, 0);
    checkOutput("reset_out_data", out_data_o, 0);
    checkOutput("reset_out_idx", out_idx_o, 0);
    checkOutput("reset_retired", retired_cnt_o, 0);
    setValid(0, 32'hA5A5_0000);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk); #1;
    checkOutput("first_rd_en", rd_en_o, 1);
    checkOutput("first_rd_addr", rd_addr_o, 0);
    checkOutput("first_clr", valid_clr_o, 1);
    checkOutput("first_clr_addr", valid_clr_addr_o, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk); #1;
    checkOutput("first_latency_gap", out_valid_o, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk); #1;
    checkOutput("first_out_valid", out_valid_o, 1);
    checkOutput("first_out_data", out_data_o, 64'hA5A5_0000);
    checkOutput("first_out_idx", out_idx_o, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk); #1;
    checkOutput("first_retired", retired_cnt_o, 1);

    // Indices 2 and 3 valid while 0 is not: nothing may issue.
    applyStimulus(1'b1, 1'b1, 1'b1);
    setValid(2, 32'h0000_0202);
    setValid(3, 32'h0000_0303);
    n_issue = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(negedge clk); #1;
      if (rd_en_o) n_issue++;
    end
    checkOutput("gap_no_issue", n_issue, 0);
    setValid(0, 32'h0000_0000);
    setValid(1, 32'h0000_0101);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(negedge clk); #1;
      if (out_valid_o && out_ready_i) begin
        acc_idx.push_back(int'(out_idx_o));
        acc_cyc.push_back(k);
      end
    end
    checkOutput("order_count", acc_idx.size(), 4);
    for (int j = 0; j < acc_idx.size(); j++) begin
      checkOutput("order_idx", acc_idx[j], j);
      checkOutput("order_b2b", acc_cyc[j] - acc_cyc[0], j);
    end

    // Full ROB with back-pressure, then drain across the wrap.
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) setValid(i, 32'h1000_0000 + i);
    n_issue = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk); #1;
      if (rd_en_o) n_issue++;
      if (out_valid_o) begin
        checkOutput("stall_hold_data", out_data_o, 64'h1000_0000);
        checkOutput("stall_hold_idx", out_idx_o, 0);
      end
    end
    checkOutput("stall_issue_count", n_issue, 2);
    acc_idx.delete();
    acc_cyc.delete();
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(negedge clk); #1;
      if (out_valid_o && out_ready_i) begin
        acc_idx.push_back(int'(out_idx_o));
        acc_cyc.push_back(k);
      end
    end
    checkOutput("drain_count", acc_idx.size(), DEPTH);
    for (int j = 0; j < acc_idx.size(); j++) begin
      checkOutput("drain_idx", acc_idx[j], j);
      checkOutput("drain_b2b", acc_cyc[j] - acc_cyc[0], j);
    end
    checkOutput("drain_retired", retired_cnt_o, DEPTH);
    checkOutput("drain_head_wrapped", valid_addr_o, 0);

    // Flush while a read is in flight.
    applyStimulus(1'b1, 1'b0, 1'b1);
    setValid(0, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk); #1;
    checkOutput("inflight_issue", rd_en_o, 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clk); #1;
    checkOutput("flush_cycle_no_issue", rd_en_o, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(negedge clk); #1;
      checkOutput("flush_out_valid", out_valid_o, 0);
      checkOutput("flush_retired", retired_cnt_o, 0);
      checkOutput("flush_head", valid_addr_o, 0);
    end

    // Reset with the skid buffer full.
    for (int i = 0; i < 8; i++) setValid(i, 32'h2000_0000 + i);
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk); #1;
    checkOutput("prereset_full", out_valid_o, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    checkOutput("reset_cycle_rd_en", rd_en_o, 0);
    checkOutput("reset_cycle_clr", valid_clr_o, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk); #1;
    checkOutput("midreset_out_valid", out_valid_o, 0);
    checkOutput("midreset_out_data", out_data_o, 0);
    checkOutput("midreset_out_idx", out_idx_o, 0);
    checkOutput("midreset_retired", retired_cnt_o, 0);
    checkOutput("midreset_head", valid_addr_o, 0);

    // Randomized traffic: random, toggling and mostly-ready back-pressure phases.
    for (int c = 0; c < 3000; c++) begin
      case ((c / 200) % 3)
        0:       ready_v = ($urandom_range(0, 1) == 1);
        1:       ready_v = ((c % 2) == 0);
        default: ready_v = ($urandom_range(0, 7) != 0);
      endcase
      applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 79) == 0), ready_v);
      if ($urandom_range(0, 1) == 1)
        setValid(int'((int'(valid_addr_o) + int'($urandom_range(0, 3))) % DEPTH), $urandom);
      if ($urandom_range(0, 3) == 0)
        setValid(int'($urandom_range(0, DEPTH - 1)), $urandom);
    end

    // Long uninterrupted stream to drive the retired counter into saturation.
    for (int c = 0; c < 100; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      for (int j = 0; j < 4; j++)
        setValid((int'(valid_addr_o) + j) % DEPTH, $urandom);
    end
    @(negedge clk); #1;
    checkOutput("retired_saturated", retired_cnt_o, CNT_MAX);

    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule

// File: doc/rob_reader.md
Name: rob_reader

Overview:
- In-order drain engine for the reorder buffer: the consumer side of the per-entry valid bitmap and the data RAM.
- Walks a head pointer, waits for the head entry's valid bit, reads the payload from the data RAM, and clears that valid bit.
- Presents entries strictly in index order on a valid/ready output stream with a 2-entry skid buffer, so downstream back-pressure never drops data.
- Sits between the valid memory / data RAM and the downstream consumer.

Parameters:
- ADDR_WIDTH, 4, log2 of ROB depth; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, payload width of one ROB entry.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush_i  input  1  synchronous flush: head to 0, skid buffer emptied, in-flight read discarded.
- valid_addr_o  output  ADDR_WIDTH  valid-bitmap read address; always equals head.
- valid_i  input  1  valid bit at valid_addr_o, combinational, same cycle.
- valid_clr_o  output  1  one-cycle per-entry clear strobe.
- valid_clr_addr_o  output  ADDR_WIDTH  entry being cleared.
- rd_en_o  output  1  data RAM read enable.
- rd_addr_o  output  ADDR_WIDTH  data RAM read address.
- rd_data_i  input  DATA_WIDTH  RAM read data, valid exactly 1 cycle after rd_en_o.
- out_valid_o  output  1  output entry available.
- out_ready_i  input  1  downstream accepts.
- out_data_o  output  DATA_WIDTH  payload.
- out_idx_o  output  ADDR_WIDTH  ROB index of the payload.
- retired_cnt_o  output  ADDR_WIDTH+1  number of entries accepted downstream since reset/flush; saturates at all-ones.

Behaviour:
- Reset (rst_n=0 at clk edge) values:
  - head=0; skid buffer empty; in-flight flag=0; retired_cnt_o=0.
  - out_valid_o=0; rd_en_o=0; valid_clr_o=0.
  - out_data_o and out_idx_o are 0.
  - Reset has priority over flush.
- Credit:
  - slots_free = 2 − (buffered entries) − (in-flight read).
  - An issue is allowed only if slots_free ≥ 1 after counting any pop in the same cycle (out_valid_o & out_ready_i).
- Issue cycle (valid_i=1, credit available, flush_i=0), all in the same cycle as the combinational decision:
  - rd_en_o=1, rd_addr_o=head, valid_clr_o=1, valid_clr_addr_o=head.
  - head <= head+1, wrapping mod depth.
  - in-flight flag <= 1.
- Capture cycle (issue+1): rd_data_i and the issued index are written into the skid buffer tail.
- Issue rate: one issue per cycle back-to-back is allowed; sustained throughput is 1 entry/cycle when out_ready_i=1.
- Latency: valid_i rising at head in cycle T with an empty buffer gives out_valid_o=1 in cycle T+2.
- Skid buffer: 2-entry FIFO.
  - out_valid_o = not empty; out_data_o/out_idx_o = FIFO head.
  - Outputs are stable while out_valid_o=1 and out_ready_i=0.
  - Push and pop in the same cycle are both honoured.
- valid_i=0 at head: stall with no rd_en_o and no clear; later indices are never skipped even if their valid bits are set.
- Wrap-around: head 2**ADDR_WIDTH−1 → 0 with no bubble.
- Flush:
  - Next cycle: head=0, buffer empty, in-flight discarded (rd_data_i ignored), retired_cnt_o=0.
  - No issue or clear in the flush cycle.
  - out_valid_o=0 in the cycle after flush.
- retired_cnt_o increments on each out_valid_o & out_ready_i; it holds at 2**(ADDR_WIDTH+1)−1.
- No combinational path from out_ready_i to rd_en_o beyond the credit term. valid_i is the only combinational input on the issue path.

Decomposition:
- Package rob_pkg:
  - default ADDR_WIDTH/DATA_WIDTH constants.
  - typedef rob_idx_t (logic [ADDR_WIDTH-1:0]).
  - typedef rob_entry_t struct {idx, data}.
- Sub-module rob_skid_fifo:
  - 2-entry FIFO of rob_entry_t with push/pop/full/empty and a 2-bit count output.
  - The count feeds the credit logic.
- Head pointer, issue, and counter logic stay in rob_reader.

Test Plan:
- Reset then valid_i=1 at index 0 with rd_data_i=0xA5A5_0000 and out_ready_i=1:
  - rd_en_o and valid_clr_o at cycle 1 with addr 0.
  - out_valid_o at cycle 3 with data 0xA5A5_0000, idx 0.
  - retired_cnt_o=1 afterwards.
- Valid bits set for indices 2 and 3 only (0,1 clear):
  - No rd_en_o for 20 cycles.
  - Set 0 and 1: output order 0,1,2,3 back-to-back, one per cycle.
- All 16 entries valid, out_ready_i=0:
  - Exactly 2 issues occur, then a stall; out_data_o stable.
  - Raise out_ready_i: remaining 14 drain in order.
  - Head wraps 15→0 with no gap; retired_cnt_o=16.
- out_ready_i toggled 1/0 each cycle with continuous valid:
  - No loss or duplicate; indices strictly increasing mod 16.
  - Skid count never exceeds 2.
- flush_i asserted in the cycle after an issue (in flight):
  - Returned rd_data_i is dropped.
  - out_valid_o=0 and retired_cnt_o=0 next cycle; head restarts at 0.
- rst_n=0 for 1 cycle mid-stream with a full buffer: all outputs return to reset values at the next edge, and there are no clears in that cycle.
